// File: rtl/mips_bus_arbiter.sv
// mips_bus_arbiter
//    Two-master arbiter for the single Avalon-style memory bus of mips_cpu_bus.
//    Port I (instruction fetch, read-only, full-word lanes) and port D
//    (load/store) compete for the bus. The winner's request is latched into the
//    bus output registers and held until the slave drops waitrequest. Ties go
//    to the port that did not own the bus most recently. A stalled transaction
//    is aborted after TIMEOUT consecutive stall cycles (0 disables the abort).
//
// Ports
//    clk, reset                       clock, asynchronous active-high reset
//    i_address, i_read                fetch request
//    i_waitrequest, i_readdata        fetch completion strobe (active low) and data
//    d_address, d_read, d_write,
//    d_writedata, d_byteenable        load/store request (write wins over read)
//    d_waitrequest, d_readdata        load/store completion strobe and data
//    address, read, write,
//    writedata, byteenable            registered bus master outputs
//    waitrequest, readdata            bus slave stall and read data
//    timeout_err                      sticky abort flag, cleared only by reset
module mips_bus_arbiter #(
   parameter logic [31:0] TIMEOUT = 32'd1024
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] i_address,
   input  logic        i_read,
   output logic        i_waitrequest,
   output logic [31:0] i_readdata,
   input  logic [31:0] d_address,
   input  logic        d_read,
   input  logic        d_write,
   input  logic [31:0] d_writedata,
   input  logic [3:0]  d_byteenable,
   output logic        d_waitrequest,
   output logic [31:0] d_readdata,
   output logic [31:0] address,
   output logic        read,
   output logic        write,
   output logic [31:0] writedata,
   output logic [3:0]  byteenable,
   input  logic        waitrequest,
   input  logic [31:0] readdata,
   output logic        timeout_err
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_BUS   = 2'd1,
      ST_ABORT = 2'd2
   } state_t;

   localparam logic OWN_I = 1'b0;
   localparam logic OWN_D = 1'b1;

   state_t      state_r, state_s;
   logic        owner_r, owner_s;
   logic        last_r, last_s;
   logic [31:0] cnt_r, cnt_s;
   logic        terr_r, terr_s;
   logic [31:0] address_r, address_s;
   logic        read_r, read_s;
   logic        write_r, write_s;
   logic [31:0] writedata_r, writedata_s;
   logic [3:0]  byteenable_r, byteenable_s;

   logic        req_i_s;
   logic        req_d_s;
   logic        grant_s;
   logic        grant_own_s;
   logic        clear_s;

   assign req_i_s = i_read;
   assign req_d_s = d_read | d_write;

   // Next-state, arbitration decision and bus output register loading.
   always_comb begin
      state_s      = state_r;
      owner_s      = owner_r;
      last_s       = last_r;
      cnt_s        = cnt_r;
      terr_s       = terr_r;
      address_s    = address_r;
      read_s       = read_r;
      write_s      = write_r;
      writedata_s  = writedata_r;
      byteenable_s = byteenable_r;
      grant_s      = 1'b0;
      grant_own_s  = owner_r;
      clear_s      = 1'b0;

      case (state_r)
         ST_IDLE: begin
            if (req_i_s && req_d_s) begin
               // Tie: favour whichever port did not own the bus last.
               grant_s     = 1'b1;
               grant_own_s = (last_r == OWN_D) ? OWN_I : OWN_D;
            end else if (req_i_s) begin
               grant_s     = 1'b1;
               grant_own_s = OWN_I;
            end else if (req_d_s) begin
               grant_s     = 1'b1;
               grant_own_s = OWN_D;
            end else begin
               grant_s     = 1'b0;
            end
         end
         ST_BUS: begin
            if (!waitrequest) begin
               last_s = owner_r;
               // Hand the bus straight to the other port if it is waiting; the
               // finishing port's still-high request is deliberately not looked at.
               if ((owner_r == OWN_I) ? req_d_s : req_i_s) begin
                  grant_s     = 1'b1;
                  grant_own_s = ~owner_r;
               end else begin
                  state_s = ST_IDLE;
                  clear_s = 1'b1;
               end
            end else begin
               cnt_s = cnt_r + 32'd1;
               if ((TIMEOUT != 32'd0) && (cnt_s == TIMEOUT)) begin
                  state_s = ST_ABORT;
                  terr_s  = 1'b1;
                  clear_s = 1'b1;
               end else begin
                  state_s = ST_BUS;
               end
            end
         end
         ST_ABORT: begin
            last_s  = owner_r;
            state_s = ST_IDLE;
            clear_s = 1'b1;
         end
         default: begin
            state_s = ST_IDLE;
            clear_s = 1'b1;
         end
      endcase

      if (grant_s) begin
         state_s = ST_BUS;
         owner_s = grant_own_s;
         cnt_s   = 32'd0;
         if (grant_own_s == OWN_D) begin
            address_s    = d_address;
            read_s       = d_read & ~d_write;
            write_s      = d_write;
            writedata_s  = d_writedata;
            byteenable_s = d_byteenable;
         end else begin
            address_s    = i_address;
            read_s       = 1'b1;
            write_s      = 1'b0;
            writedata_s  = 32'h0000_0000;
            byteenable_s = 4'b1111;
         end
      end else if (clear_s) begin
         address_s    = 32'h0000_0000;
         read_s       = 1'b0;
         write_s      = 1'b0;
         writedata_s  = 32'h0000_0000;
         byteenable_s = 4'b0000;
      end else begin
         address_s    = address_r;
      end
   end

   // State, arbitration history, timeout counter and bus output registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r      <= ST_IDLE;
         owner_r      <= OWN_I;
         last_r       <= OWN_D;
         cnt_r        <= 32'd0;
         terr_r       <= 1'b0;
         address_r    <= 32'h0000_0000;
         read_r       <= 1'b0;
         write_r      <= 1'b0;
         writedata_r  <= 32'h0000_0000;
         byteenable_r <= 4'b0000;
      end else begin
         state_r      <= state_s;
         owner_r      <= owner_s;
         last_r       <= last_s;
         cnt_r        <= cnt_s;
         terr_r       <= terr_s;
         address_r    <= address_s;
         read_r       <= read_s;
         write_r      <= write_s;
         writedata_r  <= writedata_s;
         byteenable_r <= byteenable_s;
      end
   end

   // Completion strobes and read data returned to the owning port only.
   always_comb begin
      i_waitrequest = 1'b1;
      d_waitrequest = 1'b1;
      i_readdata    = readdata;
      d_readdata    = readdata;
      case (state_r)
         ST_BUS: begin
            if (owner_r == OWN_I) begin
               i_waitrequest = waitrequest;
            end else begin
               d_waitrequest = waitrequest;
            end
         end
         ST_ABORT: begin
            if (owner_r == OWN_I) begin
               i_waitrequest = 1'b0;
               i_readdata    = 32'h0000_0000;
            end else begin
               d_waitrequest = 1'b0;
               d_readdata    = 32'h0000_0000;
            end
         end
         default: begin
            i_waitrequest = 1'b1;
            d_waitrequest = 1'b1;
         end
      endcase
   end

   assign address     = address_r;
   assign read        = read_r;
   assign write       = write_r;
   assign writedata   = writedata_r;
   assign byteenable  = byteenable_r;
   assign timeout_err = terr_r;

endmodule

// File: tb/tb_mips_bus_arbiter.sv
// Self-checking bench for mips_bus_arbiter (TIMEOUT = 4).
// Two requester drivers replay command queues with the hold-until-done
// protocol; a slave model answers with a fixed memory table and a settable
// number of wait states. Every completion seen on i/d_waitrequest is checked
// against a scoreboard of hand-computed expectations, including the cycle.
module tb_mips_bus_arbiter;

   logic        clk;
   logic        reset;
   logic [31:0] i_address;
   logic        i_read;
   logic        i_waitrequest;
   logic [31:0] i_readdata;
   logic [31:0] d_address;
   logic        d_read;
   logic        d_write;
   logic [31:0] d_writedata;
   logic [3:0]  d_byteenable;
   logic        d_waitrequest;
   logic [31:0] d_readdata;
   logic [31:0] address;
   logic        read;
   logic        write;
   logic [31:0] writedata;
   logic [3:0]  byteenable;
   logic        waitrequest;
   logic [31:0] readdata;
   logic        timeout_err;

   typedef struct {
      logic        port;
      logic [31:0] addr;
      logic        rd;
      logic        wr;
      logic [31:0] wd;
      logic [3:0]  be;
      logic [31:0] rdata;
      int          cyc;
      logic        abort;
   } exp_t;

   typedef struct {
      logic [31:0] addr;
      logic        rd;
      logic        wr;
      logic [31:0] wd;
      logic [3:0]  be;
   } dcmd_t;

   exp_t        sb[$];
   logic [31:0] iq[$];
   dcmd_t       dq[$];
   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          ws = 0;
   int          wcnt;
   logic        stuck = 1'b0;
   logic        i_done;
   logic        d_done;
   exp_t        mon_e;
   int          t0;

   mips_bus_arbiter #(.TIMEOUT(32'd4)) dut (
      .clk(clk), .reset(reset),
      .i_address(i_address), .i_read(i_read),
      .i_waitrequest(i_waitrequest), .i_readdata(i_readdata),
      .d_address(d_address), .d_read(d_read), .d_write(d_write),
      .d_writedata(d_writedata), .d_byteenable(d_byteenable),
      .d_waitrequest(d_waitrequest), .d_readdata(d_readdata),
      .address(address), .read(read), .write(write),
      .writedata(writedata), .byteenable(byteenable),
      .waitrequest(waitrequest), .readdata(readdata),
      .timeout_err(timeout_err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   // Slave: fixed memory table, unknown addresses read back DEADBEEF.
   always_comb begin
      case (address)
         32'hBFC0_0000: readdata = 32'h2402_1000;
         32'hBFC0_0004: readdata = 32'h8C43_0000;
         32'hBFC0_0008: readdata = 32'h0062_1021;
         32'hBFC0_000C: readdata = 32'hAC62_0004;
         32'h8000_0000: readdata = 32'h1111_1111;
         32'h8000_0004: readdata = 32'h2222_2222;
         32'h8000_0008: readdata = 32'h3333_3333;
         32'h8000_000C: readdata = 32'h4444_4444;
         default:       readdata = 32'hDEAD_BEEF;
      endcase
   end

   assign waitrequest = stuck | ((read | write) & (wcnt < ws));

   always @(posedge clk or posedge reset) begin
      if (reset)                       wcnt <= 0;
      else if ((read | write) && !waitrequest) wcnt <= 0;
      else if (read | write)           wcnt <= wcnt + 1;
      else                             wcnt <= 0;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic expect_tr(input logic port, input logic [31:0] addr, input logic rd,
                            input logic wr, input logic [31:0] wd, input logic [3:0] be,
                            input logic [31:0] rdata, input int c, input logic abort);
      exp_t e;
      e.port = port; e.addr = addr; e.rd = rd; e.wr = wr; e.wd = wd;
      e.be = be; e.rdata = rdata; e.cyc = c; e.abort = abort;
      sb.push_back(e);
   endtask

   task automatic push_d(input logic [31:0] addr, input logic rd, input logic wr,
                         input logic [31:0] wd, input logic [3:0] be);
      dcmd_t c;
      c.addr = addr; c.rd = rd; c.wr = wr; c.wd = wd; c.be = be;
      dq.push_back(c);
   endtask

   // Fetch requester: holds the head command until it sees completion.
   initial begin
      i_read = 1'b0; i_address = 32'h0; i_done = 1'b0;
      forever begin
         @(negedge clk);
         i_done = i_read && !i_waitrequest && !reset;
         @(posedge clk); #1;
         if (i_done && iq.size() > 0) void'(iq.pop_front());
         if (iq.size() > 0 && !reset) begin
            i_read = 1'b1; i_address = iq[0];
         end else begin
            i_read = 1'b0;
         end
      end
   end

   // Load/store requester.
   initial begin
      d_read = 1'b0; d_write = 1'b0; d_address = 32'h0; d_writedata = 32'h0;
      d_byteenable = 4'h0; d_done = 1'b0;
      forever begin
         @(negedge clk);
         d_done = (d_read || d_write) && !d_waitrequest && !reset;
         @(posedge clk); #1;
         if (d_done && dq.size() > 0) void'(dq.pop_front());
         if (dq.size() > 0 && !reset) begin
            d_read = dq[0].rd; d_write = dq[0].wr; d_address = dq[0].addr;
            d_writedata = dq[0].wd; d_byteenable = dq[0].be;
         end else begin
            d_read = 1'b0; d_write = 1'b0;
         end
      end
   end

   // Monitor: every completion is popped from the scoreboard and compared.
   initial begin
      forever begin
         @(negedge clk);
         if (!reset && (!i_waitrequest || !d_waitrequest)) begin
            chk("single_done", {31'd0, i_waitrequest | d_waitrequest}, 32'd1);
            if (sb.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_done: got i_wr=%b d_wr=%b expected no completion (cycle %0d)",
                        i_waitrequest, d_waitrequest, cyc);
            end else begin
               mon_e = sb.pop_front();
               chk("owner", {31'd0, ~d_waitrequest}, {31'd0, mon_e.port});
               chk("done_cycle", cyc, mon_e.cyc);
               chk("bus_read", {31'd0, read}, mon_e.abort ? 32'd0 : {31'd0, mon_e.rd});
               chk("bus_write", {31'd0, write}, mon_e.abort ? 32'd0 : {31'd0, mon_e.wr});
               chk("owner_rdata", mon_e.port ? d_readdata : i_readdata,
                   mon_e.abort ? 32'h0 : mon_e.rdata);
               if (!mon_e.abort) begin
                  chk("bus_address", address, mon_e.addr);
                  chk("bus_writedata", writedata, mon_e.wd);
                  chk("bus_byteenable", {28'd0, byteenable}, {28'd0, mon_e.be});
               end
            end
         end
      end
   end

   task automatic reset_checks();
      chk("rst_address", address, 32'h0);
      chk("rst_read", {31'd0, read}, 32'd0);
      chk("rst_write", {31'd0, write}, 32'd0);
      chk("rst_byteenable", {28'd0, byteenable}, 32'd0);
      chk("rst_i_waitrequest", {31'd0, i_waitrequest}, 32'd1);
      chk("rst_d_waitrequest", {31'd0, d_waitrequest}, 32'd1);
      chk("rst_timeout_err", {31'd0, timeout_err}, 32'd0);
   endtask

   task automatic wait_drain(input int maxc);
      int n = 0;
      while ((sb.size() > 0 || iq.size() > 0 || dq.size() > 0) && n < maxc) begin
         @(posedge clk);
         n++;
      end
      chk("drain_scoreboard", sb.size(), 32'd0);
      repeat (2) @(posedge clk);
   endtask

   task automatic sync();
      @(posedge clk); #3;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got no finish expected finish before time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #2;
      reset_checks();
      @(negedge clk); reset = 1'b0;

      // Single fetch, zero wait states; bus idle the cycle after.
      sync(); t0 = cyc;
      iq.push_back(32'hBFC0_0000);
      expect_tr(1'b0, 32'hBFC0_0000, 1'b1, 1'b0, 32'h0, 4'hF, 32'h2402_1000, t0 + 2, 1'b0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("idle_read", {31'd0, read}, 32'd0);
      chk("idle_address", address, 32'h0);
      wait_drain(40);

      // Tie after reset: fetch first, store back-to-back.
      @(negedge clk); reset = 1'b1; #1;
      reset_checks();
      @(negedge clk); reset = 1'b0;
      sync(); t0 = cyc;
      iq.push_back(32'hBFC0_0004);
      push_d(32'hBFC0_0010, 1'b0, 1'b1, 32'h0000_1000, 4'hF);
      expect_tr(1'b0, 32'hBFC0_0004, 1'b1, 1'b0, 32'h0, 4'hF, 32'h8C43_0000, t0 + 2, 1'b0);
      expect_tr(1'b1, 32'hBFC0_0010, 1'b0, 1'b1, 32'h0000_1000, 4'hF, 32'hDEAD_BEEF, t0 + 3, 1'b0);
      wait_drain(40);

      // Round-robin, both streaming (last owner is D).
      sync(); t0 = cyc;
      iq.push_back(32'hBFC0_0000); iq.push_back(32'hBFC0_0004); iq.push_back(32'hBFC0_0008);
      push_d(32'h8000_0000, 1'b1, 1'b0, 32'h0, 4'hF);
      push_d(32'h8000_0004, 1'b1, 1'b0, 32'h0, 4'h3);
      push_d(32'h8000_0008, 1'b1, 1'b1, 32'hCAFE_F00D, 4'hC);
      expect_tr(1'b0, 32'hBFC0_0000, 1'b1, 1'b0, 32'h0, 4'hF, 32'h2402_1000, t0 + 2, 1'b0);
      expect_tr(1'b1, 32'h8000_0000, 1'b1, 1'b0, 32'h0, 4'hF, 32'h1111_1111, t0 + 3, 1'b0);
      expect_tr(1'b0, 32'hBFC0_0004, 1'b1, 1'b0, 32'h0, 4'hF, 32'h8C43_0000, t0 + 4, 1'b0);
      expect_tr(1'b1, 32'h8000_0004, 1'b1, 1'b0, 32'h0, 4'h3, 32'h2222_2222, t0 + 5, 1'b0);
      expect_tr(1'b0, 32'hBFC0_0008, 1'b1, 1'b0, 32'h0, 4'hF, 32'h0062_1021, t0 + 6, 1'b0);
      expect_tr(1'b1, 32'h8000_0008, 1'b0, 1'b1, 32'hCAFE_F00D, 4'hC, 32'h3333_3333, t0 + 7, 1'b0);
      wait_drain(60);

      // Three wait states on a D load; fetch arriving meanwhile follows directly.
      ws = 3;
      sync(); t0 = cyc;
      push_d(32'h8000_000C, 1'b1, 1'b0, 32'h0, 4'h3);
      expect_tr(1'b1, 32'h8000_000C, 1'b1, 1'b0, 32'h0, 4'h3, 32'h4444_4444, t0 + 5, 1'b0);
      sync();
      iq.push_back(32'hBFC0_000C);
      expect_tr(1'b0, 32'hBFC0_000C, 1'b1, 1'b0, 32'h0, 4'hF, 32'hAC62_0004, t0 + 9, 1'b0);
      wait_drain(60);
      ws = 0;

      // Timeout: slave stuck, abort after four stalled granted cycles.
      stuck = 1'b1;
      sync(); t0 = cyc;
      push_d(32'h8000_0000, 1'b1, 1'b0, 32'h0, 4'hF);
      expect_tr(1'b1, 32'h8000_0000, 1'b1, 1'b0, 32'h0, 4'hF, 32'h0, t0 + 6, 1'b1);
      repeat (5) @(posedge clk);
      @(negedge clk);
      chk("terr_before_abort", {31'd0, timeout_err}, 32'd0);
      @(posedge clk); @(negedge clk);
      chk("terr_set", {31'd0, timeout_err}, 32'd1);
      wait_drain(40);
      repeat (4) @(posedge clk);
      @(negedge clk);
      chk("terr_sticky", {31'd0, timeout_err}, 32'd1);

      // Asynchronous reset while a store is stalled on the bus.
      sync(); t0 = cyc;
      push_d(32'h8000_0010, 1'b0, 1'b1, 32'h1234_5678, 4'hF);
      repeat (3) @(posedge clk);
      #4;
      chk("store_on_bus", {31'd0, write}, 32'd1);
      reset = 1'b1; #1;
      reset_checks();
      dq.delete();
      stuck = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk); reset = 1'b0;
      repeat (5) @(posedge clk);
      @(negedge clk);
      chk("no_replay", {31'd0, read | write}, 32'd0);
      chk("final_scoreboard", sb.size(), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
